// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing comes from an internal divider; ctr and stage are exported for debug.
module uart_tx #(
    parameter logic [10:0] baud_threshold = 11'd867,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned PARITY         = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_en,
    output logic        tx,
    output logic        tx_ready,
    output logic [10:0] ctr,
    output logic [4:0]  stage
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_START  = 5'd1,
        S_D0     = 5'd2,
        S_D1     = 5'd3,
        S_D2     = 5'd4,
        S_D3     = 5'd5,
        S_D4     = 5'd6,
        S_D5     = 5'd7,
        S_D6     = 5'd8,
        S_D7     = 5'd9,
        S_PARITY = 5'd10,
        S_STOP1  = 5'd11,
        S_STOP2  = 5'd12
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] ctr_q, ctr_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic [7:0]  data_q, data_d;
    state_e      nxt;

    // Stage that follows s once its bit time expires (only meaningful for non-idle stages).
    function automatic state_e next_stage(input state_e s);
        case (s)
            S_D7:    next_stage = (PARITY != 0) ? S_PARITY : S_STOP1;
            S_PARITY: next_stage = S_STOP1;
            S_STOP1: next_stage = (STOP_BITS == 2) ? S_STOP2 : S_IDLE;
            S_STOP2: next_stage = S_IDLE;
            default: next_stage = state_e'(5'(s) + 5'd1);
        endcase
    endfunction

    // Line level driven while in stage s.
    function automatic logic line_bit(input state_e s, input logic [7:0] d);
        case (s)
            S_START:  line_bit = 1'b0;
            S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7:
                      line_bit = d[3'(5'(s) - 5'd2)];
            S_PARITY: line_bit = (PARITY == 1) ? ~^d : ^d;
            default:  line_bit = 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        data_d  = data_q;
        nxt     = next_stage(state_q);
        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                ctr_d   = '0;
                if (tx_en) begin
                    data_d  = tx_data;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                end
            end
            S_START, S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7,
            S_PARITY, S_STOP1, S_STOP2: begin
                // Terminal count: move on and present the next bit on the same edge.
                if (ctr_q == baud_threshold) begin
                    ctr_d   = '0;
                    state_d = nxt;
                    tx_d    = line_bit(nxt, data_q);
                    ready_d = (nxt == S_IDLE);
                end else begin
                    ctr_d = ctr_q + 11'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ctr_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign ctr      = ctr_q;
    assign stage    = 5'(state_q);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three configurations, expected frames queued by the
// stimulus and checked by a per-instance serial monitor.
module tb_uart_tx;

    logic             clk;
    logic [2:0]       rst_w;
    logic [2:0]       en_w;
    logic [2:0]       tx_w;
    logic [2:0]       rdy_w;
    logic [2:0][7:0]  data_w;
    logic [2:0][10:0] ctr_w;
    logic [2:0][4:0]  stg_w;

    int checks = 0;
    int errors = 0;
    int last_gap [3];
    logic [12:0] exp0 [$];
    logic [12:0] exp1 [$];
    logic [12:0] exp2 [$];

    uart_tx #(.baud_threshold(11'd3), .STOP_BITS(1), .PARITY(0)) u0 (
        .clk(clk), .rst(rst_w[0]), .tx_data(data_w[0]), .tx_en(en_w[0]),
        .tx(tx_w[0]), .tx_ready(rdy_w[0]), .ctr(ctr_w[0]), .stage(stg_w[0]));
    uart_tx #(.baud_threshold(11'd3), .STOP_BITS(2), .PARITY(2)) u1 (
        .clk(clk), .rst(rst_w[1]), .tx_data(data_w[1]), .tx_en(en_w[1]),
        .tx(tx_w[1]), .tx_ready(rdy_w[1]), .ctr(ctr_w[1]), .stage(stg_w[1]));
    uart_tx #(.baud_threshold(11'd0), .STOP_BITS(1), .PARITY(1)) u2 (
        .clk(clk), .rst(rst_w[2]), .tx_data(data_w[2]), .tx_en(en_w[2]),
        .tx(tx_w[2]), .tx_ready(rdy_w[2]), .ctr(ctr_w[2]), .stage(stg_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int thr_of(input int i);
        return (i == 2) ? 0 : 3;
    endfunction

    function automatic int nbits_of(input int i);
        return (i == 0) ? 10 : ((i == 1) ? 12 : 11);
    endfunction

    task automatic push(input int i, input logic [12:0] f);
        case (i)
            0: exp0.push_back(f);
            1: exp1.push_back(f);
            default: exp2.push_back(f);
        endcase
    endtask

    // Frame vector: bit k is the k-th bit on the line (start bit in bit 0).
    task automatic monitor(input int i);
        int          gap;
        int          w;
        int          nb;
        logic [12:0] got;
        logic [12:0] e;
        logic        cur;
        bit          shape_ok;
        bit          aborted;
        bit          have;
        gap = 0;
        w   = thr_of(i) + 1;
        nb  = nbits_of(i);
        forever begin
            @(negedge clk);
            if (rst_w[i] !== 1'b1) begin
                gap = 0;
            end else if (tx_w[i] === 1'b0) begin
                last_gap[i] = gap;
                got = '0; cur = 1'b0; shape_ok = 1'b1; aborted = 1'b0;
                for (int s = 0; s < nb * w; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst_w[i] !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (s % w == 0) begin
                        cur = tx_w[i];
                        got[s / w] = cur;
                    end else if (tx_w[i] !== cur) begin
                        shape_ok = 1'b0;
                    end
                    if (rdy_w[i] !== 1'b0 || ctr_w[i] !== 11'(s % w)) shape_ok = 1'b0;
                end
                if (!aborted) begin
                    have = 1'b0; e = '0;
                    case (i)
                        0: if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
                        1: if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
                        default: if (exp2.size() > 0) begin e = exp2.pop_front(); have = 1'b1; end
                    endcase
                    check($sformatf("frame_expected_u%0d", i), int'(have), 1);
                    if (have) check($sformatf("frame_bits_u%0d", i), int'(got), int'(e));
                    check($sformatf("frame_timing_u%0d", i), int'(shape_ok), 1);
                    @(negedge clk);
                    if (rst_w[i] === 1'b1)
                        check($sformatf("idle_after_frame_u%0d", i),
                              int'({tx_w[i], rdy_w[i], stg_w[i] == 5'd0, ctr_w[i] == 11'd0}), 'hF);
                    gap = 1;
                end else begin
                    gap = 0;
                end
            end else begin
                gap++;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic wait_rdy(input int i, input logic v);
        int n;
        n = 0;
        while (rdy_w[i] !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_wait_u%0d", i), int'(n < 200), 1);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (!(rdy_w[i] === 1'b1 && stg_w[i] == 5'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_wait_u%0d", i), int'(n < 200), 1);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        @(negedge clk);
        data_w[i] = d;
        en_w[i]   = 1'b1;
        @(negedge clk);
        en_w[i]   = 1'b0;
    endtask

    initial begin
        int n;
        rst_w  = 3'b111;
        en_w   = 3'b000;
        data_w = '0;
        #2 rst_w = 3'b000;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_tx_u%0d", i), int'(tx_w[i]), 1);
            check($sformatf("reset_ready_u%0d", i), int'(rdy_w[i]), 1);
            check($sformatf("reset_ctr_u%0d", i), int'(ctr_w[i]), 0);
            check($sformatf("reset_stage_u%0d", i), int'(stg_w[i]), 0);
        end
        rst_w = 3'b111;

        // 0x55, with tx_data/tx_en disturbed mid-frame (must be ignored)
        push(0, 13'b1010101010);
        send(0, 8'h55);
        repeat (10) @(negedge clk);
        data_w[0] = 8'h0F;
        en_w[0]   = 1'b1;
        @(negedge clk);
        en_w[0]   = 1'b0;
        wait_idle(0);
        push(0, 13'b1000011110);
        send(0, 8'h0F);
        wait_idle(0);

        // tx_en held high: two back-to-back 0xA3 frames
        push(0, 13'b1101000110);
        push(0, 13'b1101000110);
        @(negedge clk);
        data_w[0] = 8'hA3;
        en_w[0]   = 1'b1;
        wait_rdy(0, 1'b0);
        wait_rdy(0, 1'b1);
        wait_rdy(0, 1'b0);
        en_w[0]   = 1'b0;
        wait_idle(0);
        check("back_to_back_idle_clks", last_gap[0], 1);

        push(0, 13'b1111111110);
        send(0, 8'hFF);
        wait_idle(0);

        // asynchronous reset during data bit 3 of 0xC3 (bit 3 is 0 on the line)
        send(0, 8'hC3);
        n = 0;
        while (stg_w[0] != 5'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_data_bit3", int'(n < 200), 1);
        check("pre_reset_tx_low", int'(tx_w[0]), 0);
        #1 rst_w[0] = 1'b0;
        #1;
        check("async_reset_tx", int'(tx_w[0]), 1);
        check("async_reset_stage", int'(stg_w[0]), 0);
        check("async_reset_ready", int'(rdy_w[0]), 1);
        check("async_reset_ctr", int'(ctr_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_w[0] = 1'b1;
        push(0, 13'b1010101010);
        send(0, 8'h55);
        wait_idle(0);

        // even parity, two stop bits
        push(1, 13'b111000001110);
        send(1, 8'h07);
        wait_idle(1);
        push(1, 13'b110000000000);
        send(1, 8'h00);
        wait_idle(1);

        // odd parity, one-clock bits
        push(2, 13'b10000001110);
        send(2, 8'h07);
        wait_idle(2);
        push(2, 13'b11000000110);
        send(2, 8'h03);
        wait_idle(2);

        repeat (5) @(negedge clk);
        check("frames_outstanding", exp0.size() + exp1.size() + exp2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
